// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared defaults and mode encodings for the clock-enable divider
package clkdiv_pkg;

  localparam int WIDTH_DEF       = 8;
  localparam int DEFAULT_DIV_DEF = 2;

  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

endpackage

// File: rtl/clkdiv_shadow.sv
// rtl/clkdiv_shadow.sv - pending-divisor shadow register with wrap-aligned adoption
// Ports: clk, CLR (sync, active-high), LOAD/DIV (divisor request), W (period wrap),
//        div_r (active divisor), LOAD_ACK (one-cycle adoption strobe).
module clkdiv_shadow
  import clkdiv_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DIV,
  input  logic             W,
  output logic [WIDTH-1:0] div_r,
  output logic             LOAD_ACK
);

  logic [WIDTH-1:0] pend_div;
  logic             pend;
  logic [WIDTH-1:0] div_fix;

  // A zero divisor would never wrap; treat it as divide-by-1.
  assign div_fix = (DIV == '0) ? WIDTH'(1) : DIV;

  always_ff @(posedge clk) begin
    if (CLR) begin
      div_r    <= WIDTH'(DEFAULT_DIV);
      pend_div <= WIDTH'(DEFAULT_DIV);
      pend     <= 1'b0;
      LOAD_ACK <= 1'b0;
    end else begin
      LOAD_ACK <= 1'b0;
      if (W && (LOAD || pend)) begin
        // A request arriving on the wrap itself bypasses the shadow.
        div_r    <= LOAD ? div_fix : pend_div;
        pend     <= 1'b0;
        LOAD_ACK <= 1'b1;
      end else if (LOAD) begin
        pend_div <= div_fix;
        pend     <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_divn.sv
// rtl/clk_divn.sv - runtime-programmable clock-enable divider with square/pulse output
// Ports: clk, CLR (sync, active-high), T (count enable), DIV/LOAD (divisor request),
//        MODE (0 square, 1 pulse), Q (divided output), TICK (period-end strobe),
//        LOAD_ACK (new divisor adopted).
module clk_divn
  import clkdiv_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             T,
  input  logic [WIDTH-1:0] DIV,
  input  logic             LOAD,
  input  logic             MODE,
  output logic             Q,
  output logic             TICK,
  output logic             LOAD_ACK
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH:0]   half;
  logic             w;
  logic             q_next;

  // Divisors 0/1 wrap on every enabled cycle.
  assign w = T & ((div_r <= WIDTH'(1)) || (cnt == div_r - WIDTH'(1)));

  // ceil(div_r/2) computed one bit wider so div_r = 2^WIDTH-1 cannot overflow.
  assign half = ({1'b0, div_r} + (WIDTH+1)'(1)) >> 1;

  always_comb begin
    cnt_next = cnt;
    q_next   = Q;
    if (T) begin
      cnt_next = w ? '0 : cnt + WIDTH'(1);
    end
    if (mode_e'(MODE) == MODE_PULSE) begin
      q_next = w;
    end else if (T) begin
      q_next = ({1'b0, cnt_next} >= half);
    end
  end

  always_ff @(posedge clk) begin
    if (CLR) begin
      cnt  <= '0;
      Q    <= 1'b0;
      TICK <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      Q    <= q_next;
      TICK <= w;
    end
  end

  clkdiv_shadow #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_shadow (
    .clk      (clk),
    .CLR      (CLR),
    .LOAD     (LOAD),
    .DIV      (DIV),
    .W        (w),
    .div_r    (div_r),
    .LOAD_ACK (LOAD_ACK)
  );

endmodule

// File: tb/tb_clk_divn.sv
// tb/tb_clk_divn.sv - directed table and sequence checks for clk_divn
module tb_clk_divn;

  logic       clk;
  logic       CLR;
  logic       T;
  logic [7:0] DIV;
  logic       LOAD;
  logic       MODE;
  logic       Q;
  logic       TICK;
  logic       LOAD_ACK;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic       clr;
    logic       t;
    logic       load;
    logic [7:0] div;
    logic       mode;
    logic       q;
    logic       tick;
    logic       ack;
  } vec_t;

  vec_t vecs[$];

  clk_divn #(.WIDTH(8), .DEFAULT_DIV(2)) dut (
    .clk      (clk),
    .CLR      (CLR),
    .T        (T),
    .DIV      (DIV),
    .LOAD     (LOAD),
    .MODE     (MODE),
    .Q        (Q),
    .TICK     (TICK),
    .LOAD_ACK (LOAD_ACK)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic clr, input logic t, input logic load,
                     input logic [7:0] div, input logic mode);
    CLR  = clr;
    T    = t;
    LOAD = load;
    DIV  = div;
    MODE = mode;
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string name, input logic q, input logic tick, input logic ack);
    chk({name, ".Q"}, Q, q);
    chk({name, ".TICK"}, TICK, tick);
    chk({name, ".ACK"}, LOAD_ACK, ack);
  endtask

  task automatic add(input logic clr, input logic t, input logic load, input logic [7:0] div,
                     input logic mode, input logic q, input logic tick, input logic ack);
    vec_t v;
    v.clr = clr; v.t = t; v.load = load; v.div = div; v.mode = mode;
    v.q = q; v.tick = tick; v.ack = ack;
    vecs.push_back(v);
  endtask

  // Reset, then adopt divisor n via a LOAD on the first cycle (adopted at the
  // first divide-by-2 wrap, two edges after release).
  task automatic start_with(input logic [7:0] n, input logic mode);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk3("reset", 0, 0, 0);
    cyc(0, 1, 1, n, mode);
    chk("start.ack0", LOAD_ACK, 1'b0);
    cyc(0, 1, 0, 0, mode);
    chk("start.ack1", LOAD_ACK, 1'b1);
    chk("start.tick", TICK, 1'b1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    CLR = 1; T = 0; LOAD = 0; DIV = 0; MODE = 0;

    // Default divide-by-2, then LOAD 5 adopted at the next wrap.
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 0);
    add(0, 1, 1, 5, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].clr, vecs[i].t, vecs[i].load, vecs[i].div, vecs[i].mode);
      chk3($sformatf("vec%0d", i), vecs[i].q, vecs[i].tick, vecs[i].ack);
    end

    // Mid-period change: N=8 running, LOAD 3 at cnt=2.
    start_with(8, 0);
    for (int k = 1; k <= 14; k++) begin
      logic et, ea, eq;
      cyc(0, 1, (k == 3), 3, 0);
      et = (k == 8) || (k == 11) || (k == 14);
      ea = (k == 8);
      eq = (k <= 8) ? (k >= 4 && k <= 7) : (((k - 8) % 3) == 2);
      chk3($sformatf("mid.k%0d", k), eq, et, ea);
    end

    // Enable gating: N=4, hold T low for 6 cycles mid-period.
    start_with(4, 0);
    cyc(0, 1, 0, 0, 0);
    chk3("gate.e1", 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk3("gate.e2", 1, 0, 0);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 0, 0, 0);
      chk3($sformatf("gate.hold%0d", k), 1, 0, 0);
    end
    cyc(0, 1, 0, 0, 0);
    chk3("gate.e3", 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk3("gate.e4", 0, 1, 0);

    // LOAD DIV=0 behaves as divide-by-1.
    start_with(0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 0, 0, 0);
      chk3($sformatf("div0.k%0d", k), 0, 1, 0);
    end

    // LOAD coincident with a wrap (N=1 wraps every cycle) bypasses the shadow;
    // pulse mode with N=6 gives Q identical to TICK.
    cyc(0, 1, 1, 6, 1);
    chk3("pulse.adopt", 1, 1, 1);
    for (int k = 1; k <= 12; k++) begin
      logic et;
      cyc(0, 1, 0, 0, 1);
      et = ((k % 6) == 0);
      chk3($sformatf("pulse.k%0d", k), et, et, 0);
    end

    // CLR with a request pending: request discarded, divisor back to 2.
    start_with(7, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 3, 0);
    chk3("clr.pend", 1, 0, 0);
    cyc(1, 1, 1, 5, 0);
    chk3("clr.asserted", 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      cyc(0, 1, 0, 0, 0);
      chk3($sformatf("clr.k%0d", k), (k % 2) == 1, (k % 2) == 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_divn.md
# clk_divn

Parametrised, runtime-programmable clock-enable divider, the successor to the fixed divide-by-2 toggle stage. Divides `clk` by an integer N in 1..2^WIDTH-1 and produces either a near-50 % square wave or a one-cycle pulse on `Q`, plus a period-end strobe `TICK`. Divisor changes are glitch-free: a new N takes effect only at a period boundary and is acknowledged. It sits wherever the design needs slow enables or derived rates from the single system clock.

## Interface
- `WIDTH`, 8, width of divisor and internal counter
- `DEFAULT_DIV`, 2, divisor after reset; must satisfy 1 <= DEFAULT_DIV <= 2^WIDTH-1
- `clk`  in  1  system clock, rising edge; one clock domain
- `CLR`  in  1  reset, synchronous, active-high
- `T`  in  1  count enable; 1 = advance, 0 = hold
- `DIV`  in  WIDTH  requested divisor N; 0 is treated as 1
- `LOAD`  in  1  one-cycle request to adopt `DIV`
- `MODE`  in  1  0 = square output, 1 = pulse output
- `Q`  out  1  divided output (registered)
- `TICK`  out  1  one-cycle strobe at period end (registered)
- `LOAD_ACK`  out  1  one-cycle strobe: pending divisor adopted

## Operation
- State: `cnt` (WIDTH), active divisor `div_r` (WIDTH), shadow `pend_div` (WIDTH), flag `pend`.
- CLR=1 (highest priority, ignores LOAD/T): cnt=0, div_r=DEFAULT_DIV, pend=0, Q=0, TICK=0, LOAD_ACK=0.
- Wrap condition W = T & (cnt == div_r-1); div_r of 0/1 gives W = T every cycle.
- T=1: cnt_next = W ? 0 : cnt+1. T=0: cnt, Q hold; TICK=0.
- TICK <= W.
- MODE=0: Q <= (cnt_next >= ceil(div_r/2)) when T=1; Q low ceil(N/2) enabled cycles, high floor(N/2). N=1: Q stays 0. N=2: Q toggles every enabled cycle.
- MODE=1: Q <= W (identical to TICK). MODE change takes effect on the next enabled edge; no counter disturbance.
- LOAD=1: pend_div <= (DIV==0 ? 1 : DIV), pend <= 1; a second LOAD before adoption overwrites pend_div.
- Adoption: on W with pend=1, div_r <= pend_div, pend <= 0, LOAD_ACK <= 1. LOAD coincident with W: the coincident DIV is adopted at that same wrap (bypass shadow).
- LOAD with T held 0: stays pending indefinitely; no ACK until a wrap.
- The period in progress always completes with the old divisor; no truncated or stretched Q phases.

## Timing
- All outputs registered; TICK, LOAD_ACK high exactly one cycle.
- From CLR release with T=1 and N: first TICK after the Nth rising edge; then every N enabled edges.
- MODE=0: first Q rise after ceil(N/2) enabled edges.
- LOAD_ACK is coincident with the TICK that ends the last old-divisor period; the next period uses the new N.
- CLR mid-period or mid-pending: pending request discarded, divisor returns to DEFAULT_DIV.

## Structure
- Package `clkdiv_pkg`: default WIDTH, DEFAULT_DIV, MODE encodings (MODE_SQUARE=0, MODE_PULSE=1).
- Single module; the LOAD/shadow/ACK logic may be a sub-module `clkdiv_shadow` (inputs: clk, CLR, LOAD, DIV, W; outputs: div_r, LOAD_ACK).
- Expected RTL size: 120-200 lines.

## Test plan
- Default: CLR 2 cycles then T=1, MODE=0, no LOAD -> Q toggles every clk (divide-by-2), TICK every 2nd cycle, coincident with Q falling.
- N=5: LOAD DIV=5 before first wrap -> after ACK, Q low 3 / high 2 cycles, TICK every 5 cycles, LOAD_ACK once.
- Mid-period change: N=8 running, LOAD DIV=3 at cnt=2 -> current period completes at 8 cycles, ACK with that TICK, then 3-cycle periods.
- Enable gating: N=4, T low 6 cycles mid-period -> cnt and Q frozen, TICK=0, period resumes and ends after 4 enabled edges total.
- Boundaries: LOAD DIV=0 -> behaves as N=1 (TICK every cycle, Q=0 in MODE=0); MODE=1 with N=6 -> Q is a single-cycle pulse every 6 cycles equal to TICK.
- CLR mid-operation: N=7, LOAD pending, assert CLR -> next cycle Q=0, TICK=0, no LOAD_ACK, divisor back to 2.
